// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the board-link UART (receiver and transmitter).
//   state_t           : FSM state encoding IDLE/START/DATA/STOP/BREAK
//   CLKS_PER_BIT_9600 : clk cycles per bit at 9600 baud from a 100 MHz clock
//   START_BIT/STOP_BIT: line levels of the frame delimiters
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam int unsigned CLKS_PER_BIT_9600 = 32'd10416;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2
// Two-flop synchroniser for a single asynchronous input.
//   clk     : destination clock
//   i_reset : synchronous active-high reset, loads RESET_VAL into both flops
//   i_d     : asynchronous input
//   o_q     : synchronised output, two clk cycles late
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      meta_r <= RESET_VAL;
      o_q    <= RESET_VAL;
    end else begin
      meta_r <= i_d;
      o_q    <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// UART receiver: idle-high line, 1 start bit, DATAWIDTH data bits LSB-first,
// 1 stop bit, no parity. Each bit is sampled at its mid-period.
//   clk         : system clock
//   i_reset     : synchronous active-high reset
//   i_rx_data   : asynchronous serial line, idle high
//   i_ready     : consumer accepts o_data when o_valid & i_ready
//   o_data      : last good received word
//   o_valid     : o_data holds an unconsumed word
//   o_busy      : receiver is in any state other than IDLE
//   o_frame_err : one-cycle pulse when a stop bit samples low
//   o_overrun   : one-cycle pulse when a good word is dropped because o_valid=1
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_rx_data,
  input  logic                 i_ready,
  output logic [DATAWIDTH-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATAWIDTH + 1);

  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH - 1);

  logic                 rx_s;
  state_t               state_r;
  logic [CW-1:0]        clk_cnt_r;
  logic [BW-1:0]        bit_idx_r;
  logic [DATAWIDTH-1:0] shift_r;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .i_reset (i_reset),
    .i_d     (i_rx_data),
    .o_q     (rx_s)
  );

  // Receive FSM with counters, shift register and all registered outputs.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_r     <= IDLE;
      clk_cnt_r   <= '0;
      bit_idx_r   <= '0;
      shift_r     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;

      // Accept clears o_valid; a word completing this same cycle overrides it below.
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          clk_cnt_r <= '0;
          if (rx_s == START_BIT) begin
            state_r <= START;
            o_busy  <= 1'b1;
          end else begin
            o_busy  <= 1'b0;
          end
        end

        START: begin
          if (clk_cnt_r == HALF_CNT) begin
            clk_cnt_r <= '0;
            bit_idx_r <= '0;
            if (rx_s == START_BIT) begin
              state_r <= DATA;
            end else begin
              // Start bit did not hold to mid-period: treat as a glitch.
              state_r <= IDLE;
              o_busy  <= 1'b0;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end

        DATA: begin
          if (clk_cnt_r == LAST_CNT) begin
            clk_cnt_r <= '0;
            // Shift right so the first (LSB) bit ends up at bit 0.
            shift_r   <= {rx_s, shift_r[DATAWIDTH-1:1]};
            if (bit_idx_r == LAST_BIT) begin
              state_r   <= STOP;
              bit_idx_r <= '0;
            end else begin
              bit_idx_r <= bit_idx_r + BW'(1);
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end

        STOP: begin
          if (clk_cnt_r == LAST_CNT) begin
            clk_cnt_r <= '0;
            if (rx_s == STOP_BIT) begin
              state_r <= IDLE;
              o_busy  <= 1'b0;
              if (o_valid && !i_ready) begin
                o_overrun <= 1'b1;
              end else begin
                o_data  <= shift_r;
                o_valid <= 1'b1;
              end
            end else begin
              // Line still low at stop: wait in BREAK so it cannot retrigger.
              state_r     <= BREAK;
              o_frame_err <= 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end

        BREAK: begin
          clk_cnt_r <= '0;
          if (rx_s == STOP_BIT) begin
            state_r <= IDLE;
            o_busy  <= 1'b0;
          end else begin
            o_busy  <= 1'b1;
          end
        end

        default: begin
          state_r   <= IDLE;
          clk_cnt_r <= '0;
          bit_idx_r <= '0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int DW  = 8;
  localparam int CPB = 16;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_rx_data = 1'b1;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_busy;
  logic          o_frame_err;
  logic          o_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] word_q[$];
  int            ev_q[$];
  bit            pending = 1'b0;
  logic [DW-1:0] held_word = '0;

  always #5 clk = ~clk;

  uart_rx #(.DATAWIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serial frame on the line; the line is left at the stop-bit level.
  task automatic drive_frame(input logic [DW-1:0] d, input bit stop_ok);
    i_rx_data = 1'b0;
    tick(CPB);
    for (int i = 0; i < DW; i++) begin
      i_rx_data = d[i];
      tick(CPB);
    end
    i_rx_data = stop_ok;
    tick(CPB);
  endtask

  // Reference model: what a frame should produce given the consumer state.
  task automatic expect_frame(input logic [DW-1:0] d, input bit stop_ok);
    if (!stop_ok) begin
      ev_q.push_back(EV_FERR);
    end else if (pending) begin
      ev_q.push_back(EV_OVR);
    end else begin
      word_q.push_back(d);
      if (!i_ready) begin
        pending   = 1'b1;
        held_word = d;
      end
    end
  endtask

  // Monitor: compares every DUT event against the scoreboard queues.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_frame_err) begin
        if (ev_q.size() == 0) check("unexpected_frame_err", 32'd1, 32'd0);
        else check("frame_err_event", EV_FERR, ev_q.pop_front());
      end
      if (o_overrun) begin
        if (ev_q.size() == 0) check("unexpected_overrun", 32'd1, 32'd0);
        else check("overrun_event", EV_OVR, ev_q.pop_front());
      end
      if (o_valid && i_ready) begin
        if (word_q.size() == 0) check("unexpected_word", {24'd0, o_data}, 32'hFFFF_FFFF);
        else check("word_data", {24'd0, o_data}, {24'd0, word_q.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [DW-1:0] d;
    bit ok;

    // Reset state
    tick(3);
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_data", o_data, 8'h00);
    check("rst_flags", {o_frame_err, o_overrun}, 2'b00);
    i_reset = 1'b0;
    tick(5);

    // 1: 0xA5 with latency measurement
    i_ready = 1'b1;
    expect_frame(8'hA5, 1'b1);
    n = 0;
    fork
      drive_frame(8'hA5, 1'b1);
      begin
        while (n < 400) begin
          @(posedge clk);
          n++;
          #1;
          if (o_valid) break;
        end
        check("latency", n, 32'd155);
        tick(1);
        check("valid_one_cycle", o_valid, 1'b0);
      end
    join
    tick(10);

    // 2: start-bit glitch
    i_rx_data = 1'b0;
    tick(4);
    i_rx_data = 1'b1;
    check("glitch_busy_high", o_busy, 1'b1);
    tick(30);
    check("glitch_busy_low", o_busy, 1'b0);
    check("glitch_valid", o_valid, 1'b0);

    // 3: framing error, held break, then a good frame
    expect_frame(8'h3C, 1'b0);
    drive_frame(8'h3C, 1'b0);
    tick(40);
    check("break_busy", o_busy, 1'b1);
    check("break_valid", o_valid, 1'b0);
    i_rx_data = 1'b1;
    tick(20);
    check("break_released", o_busy, 1'b0);
    expect_frame(8'h55, 1'b1);
    drive_frame(8'h55, 1'b1);
    tick(10);

    // 4: overrun with consumer stalled
    i_ready = 1'b0;
    expect_frame(8'h11, 1'b1);
    drive_frame(8'h11, 1'b1);
    expect_frame(8'h22, 1'b1);
    drive_frame(8'h22, 1'b1);
    tick(5);
    check("ovr_valid_held", o_valid, 1'b1);
    check("ovr_data_held", o_data, held_word);
    i_ready = 1'b1;
    pending = 1'b0;
    tick(2);
    check("ovr_valid_cleared", o_valid, 1'b0);

    // 5: reset mid-DATA of 0xFF, then 0x81
    fork
      drive_frame(8'hFF, 1'b1);
      begin
        tick(60);
        i_reset = 1'b1;
        tick(1);
        check("midrst_data", o_data, 8'h00);
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_flags", {o_frame_err, o_overrun}, 2'b00);
        i_reset = 1'b0;
      end
    join
    tick(10);
    expect_frame(8'h81, 1'b1);
    drive_frame(8'h81, 1'b1);
    tick(5);

    // 6: three back-to-back frames, no idle gap
    expect_frame(8'h00, 1'b1);
    expect_frame(8'hFF, 1'b1);
    expect_frame(8'h5A, 1'b1);
    drive_frame(8'h00, 1'b1);
    drive_frame(8'hFF, 1'b1);
    drive_frame(8'h5A, 1'b1);
    tick(10);

    // Randomised frames, occasional bad stop bits, random gaps
    for (int k = 0; k < 14; k++) begin
      d  = DW'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      expect_frame(d, ok);
      drive_frame(d, ok);
      if (!ok) begin
        tick($urandom_range(0, 30));
        i_rx_data = 1'b1;
        tick($urandom_range(4, 20));
      end else begin
        tick($urandom_range(0, 20));
      end
    end

    tick(40);
    check("words_drained", word_q.size(), 32'd0);
    check("events_drained", ev_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver that consumes the TX line format on the board link: idle-high, 1 start bit (0), DATAWIDTH data bits LSB-first, 1 stop bit (1), no parity, 9600 baud at 100 MHz.
- Synchronises the asynchronous input and samples each bit mid-period.
- Delivers each received word on a valid/ready interface to the SoC bus-side logic.
- Flags framing errors and overruns.

Parameters:
DATAWIDTH, 8, data bits per frame
CLKS_PER_BIT, 10416, clk cycles per bit period (100 MHz / 9600); must be >= 4 and even; benches use 16

Ports:
clk  input  1  system clock
i_reset  input  1  synchronous active-high reset
i_rx_data  input  1  asynchronous serial line, idle high
i_ready  input  1  consumer accepts o_data when o_valid & i_ready
o_data  output  DATAWIDTH  last good received word; reset 0
o_valid  output  1  o_data holds an unconsumed word; reset 0
o_busy  output  1  high in any state other than IDLE; reset 0
o_frame_err  output  1  one-cycle pulse when the stop bit samples 0; reset 0
o_overrun  output  1  one-cycle pulse when a good frame completes while o_valid=1; reset 0

Behaviour:
- Reset (synchronous, active-high): state IDLE, all counters 0, all outputs 0, synchroniser flops preset to 1. Reset mid-frame aborts the frame with no output.
- Synchroniser: 2 flops on i_rx_data. The FSM sees only the synchronised value (rx_s), 2 cycles late.
- Counters:
  - clk_cnt, width ceil(log2(CLKS_PER_BIT)), clears on every state change.
  - bit_idx, width ceil(log2(DATAWIDTH+1)).
- IDLE:
  - rx_s=0 -> START, clk_cnt=0.
- START:
  - At clk_cnt == CLKS_PER_BIT/2-1, sample rx_s.
  - rx_s=0 -> DATA, bit_idx=0.
  - rx_s=1 -> IDLE (glitch rejected, no flags).
- DATA:
  - At clk_cnt == CLKS_PER_BIT-1, shift rx_s into shift register MSB, shifting right, so the word ends LSB-first. Then bit_idx+1.
  - After the DATAWIDTH-th sample -> STOP.
- STOP:
  - At clk_cnt == CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1, o_valid=0: o_data<=shift reg, o_valid<=1 next cycle, -> IDLE.
  - rx_s=1, o_valid=1: o_data unchanged (new word dropped), o_overrun pulse, -> IDLE.
  - rx_s=0: o_frame_err pulse, word discarded, -> BREAK.
- BREAK:
  - Stay until rx_s=1, then -> IDLE. Prevents a held-low line from retriggering.
- Handshake:
  - o_valid clears the cycle after o_valid & i_ready.
  - i_ready while o_valid=0 is ignored.
  - If the accept and a new word's completion fall on the same cycle, the new word loads and o_valid stays 1. No overrun is flagged.
- Latency: line falling edge to o_valid rise = 2 + CLKS_PER_BIT/2 + (DATAWIDTH+1)*CLKS_PER_BIT + 1 cycles.
- A back-to-back frame whose start bit arrives immediately after the stop-bit sample is received correctly. IDLE sees rx_s=0 on the cycle it is entered.

Decomposition:
- Shared package uart_pkg: state encoding localparams IDLE/START/DATA/STOP/BREAK, default baud constant CLKS_PER_BIT_9600=10416, frame-format constants (START_BIT=0, STOP_BIT=1). The TX side adopts the same package.
- One sub-module: uart_sync2 (2-flop synchroniser, reset value parameterised, default 1). Reusable for other async inputs.

Test Plan:
All scenarios use CLKS_PER_BIT=16, DATAWIDTH=8.
1. Send 0xA5 with a correct frame and i_ready=1 -> o_valid pulses one cycle with o_data=0xA5 at the computed latency (2+8+144+1=155 cycles after the falling edge). No error flags.
2. Start-bit glitch: line low 4 cycles, then high -> FSM returns to IDLE, o_busy drops, no o_valid, no flags.
3. Send 0x3C with the stop bit driven 0, then hold low 40 cycles, then release -> one o_frame_err pulse, o_valid stays 0. FSM stays in BREAK until release; a following 0x55 frame is received correctly.
4. Send 0x11 then 0x22 back-to-back with i_ready=0 -> o_data=0x11, o_valid=1, one o_overrun pulse at the 0x22 stop sample. Raising i_ready then clears o_valid.
5. Raise i_reset mid-DATA of frame 0xFF -> all outputs 0 the next cycle, no o_valid. A subsequent 0x81 frame is received correctly.
6. Three back-to-back frames 0x00, 0xFF, 0x5A with i_ready=1 and no idle gap -> three o_valid pulses carrying exactly those values, no flags.
